base_sram_ctrl: RTL and testbench
=================================

Name: base_sram_ctrl

Overview:
- SRAM-side responder for the instruction fetch path: the far end of the inst_i/inst_stop interface that the instruction cache consumes.
- Owns the shared base SRAM pins and arbitrates between instruction fetch and data load/store, with data having priority.
- Generates SRAM control timing and returns fetch words on inst_rdata.
- Raises inst_stop whenever the data port holds or requests the bus.

Parameters:
- RD_WAIT, 2, wait cycles before a data read is sampled; matches the cache's two wait states before READ_SRAM.
- WR_PULSE, 1, cycles we_n is held low per write.
- ADDR_W, 20, SRAM word-address width, taken from byte address bits [21:2].

Ports:
- clk  in  1  clock
- rst  in  1  reset
- inst_addr  in  32  fetch byte address (cache rom_addr)
- inst_rdata  out  32  registered fetch word (cache inst_i)
- inst_stop  out  1  bus owned or requested by data port; cache must not start or complete a fill
- data_req  in  1  data access request; held until data_ready
- data_we  in  1  1 = write, 0 = read
- data_be  in  4  byte enables, active high
- data_addr  in  32  data byte address
- data_wdata  in  32  write data
- data_rdata  out  32  read data, valid when data_ready=1
- data_ready  out  1  one-cycle completion pulse
- base_ram_addr  out  ADDR_W  SRAM address
- base_ram_data  inout  32  SRAM data bus
- base_ram_be_n  out  4  byte enables, active low
- base_ram_ce_n  out  1  chip enable, active low
- base_ram_oe_n  out  1  output enable, active low
- base_ram_we_n  out  1  write enable, active low

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. Reset is valid at any time, including mid-operation.
  - On reset: state=IDLE, counter=0, inst_rdata=0, data_rdata=0, data_ready=0.
  - SRAM pins: ce_n=1, oe_n=1, we_n=1, be_n=4'hF, addr=0, data bus high-Z.
  - An aborted write leaves we_n high on the same edge.
- States: IDLE, DRD, WSETUP, WPULSE, WHOLD, DONE.
- IDLE, instruction mode:
  - Pins: ce_n=0, oe_n=0, we_n=1, be_n=0, addr=inst_addr[21:2], bus high-Z.
  - inst_rdata <= base_ram_data every clock edge.
  - A fetch address held stable for 3 edges yields a valid word, matching the cache's WAIT1/WAIT2/READ_SRAM sequence.
- IDLE with data_req=1: data_we=0 goes to DRD, data_we=1 goes to WSETUP. inst_rdata is not updated once the controller leaves IDLE.
- DRD:
  - Pins: addr=data_addr[21:2], oe_n=0, be_n=0.
  - Counter counts RD_WAIT cycles, then data_rdata <= base_ram_data and state goes to DONE.
  - Latency: data_req to data_ready is RD_WAIT+2 cycles.
- WSETUP: addr and data driven, we_n=1, 1 cycle, then WPULSE.
- WPULSE: we_n=0, oe_n=1, be_n=~data_be, for WR_PULSE cycles, then WHOLD.
- WHOLD: we_n=1, addr and data still driven, 1 cycle, then DONE.
- DONE: data_ready=1 for exactly 1 cycle, bus released, state returns to IDLE.
- inst_stop is combinational: (state!=IDLE) | data_req. It falls the cycle after DONE unless data_req is re-asserted.
- Back-to-back data requests: data_req high in the IDLE cycle after DONE starts a new access immediately, so a fetch cannot win that cycle (data priority is by design).
- oe_n and we_n are never low in the same cycle. The data bus is driven only in WSETUP, WPULSE and WHOLD.
- data_addr[1:0] and inst_addr[1:0] are ignored. Range decoding to base RAM is the caller's job.

Optional Feature:
- Macro: SRAM_BYTE_WRITE_EN.
- Defined: base_ram_be_n=~data_be during WPULSE, giving byte/halfword stores (SB/SH).
- Undefined: data_be is ignored and writes use be_n=4'h0 (full-word only).

Test Plan:
- Reset mid-WPULSE (write 0xDEADBEEF to 0x80000010, rst asserted during WPULSE) -> we_n=1, ce_n=1, bus high-Z immediately; data_ready never pulses.
- Fetch 0x80000040 with SRAM model word 0x3C011234 -> inst_rdata=0x3C011234 on 3rd edge; inst_stop=0 throughout; addr=0x00010.
- Data read 0x80000100 (model 0xCAFEF00D) -> inst_stop=1 from request cycle; data_ready at cycle RD_WAIT+2=4; data_rdata=0xCAFEF00D.
- Write 0x11223344 to 0x80000200 with be=4'b0011 (feature on) -> we_n low exactly 1 cycle with be_n=4'b1100; readback gives 0xXXXX3344 (upper bytes unchanged). Feature off: be_n=0, full word written.
- Fetch in progress plus simultaneous data_req -> data wins; inst_stop=1 same cycle; after DONE, instruction mode resumes and the fetch word is valid 3 edges later.
- Two back-to-back data writes -> no fetch window between them; exactly two data_ready pulses; oe_n/we_n never both low.

Source files
------------

// File: rtl/base_sram_ctrl.sv
// Base SRAM controller: serves instruction fetches in IDLE and gives data load/store priority.
// Optional macro SRAM_BYTE_WRITE_EN enables byte-masked writes; otherwise writes are full-word.
module base_sram_ctrl #(
  parameter int RD_WAIT  = 2,
  parameter int WR_PULSE = 1,
  parameter int ADDR_W   = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst_addr,
  output logic [31:0]       inst_rdata,
  output logic              inst_stop,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [3:0]        data_be,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       data_wdata,
  output logic [31:0]       data_rdata,
  output logic              data_ready,
  output logic [ADDR_W-1:0] base_ram_addr,
  inout  wire  [31:0]       base_ram_data,
  output logic [3:0]        base_ram_be_n,
  output logic              base_ram_ce_n,
  output logic              base_ram_oe_n,
  output logic              base_ram_we_n,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {IDLE, DRD, WSETUP, WPULSE, WHOLD, DONE} state_t;
  localparam int CNT_W = 8;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       inst_rdata_q, data_rdata_q;
  logic              bus_drive;
  logic [3:0]        wr_be_n;
  logic              unused_bits;

`ifdef SRAM_BYTE_WRITE_EN
  assign wr_be_n = ~data_be;
  assign unused_bits = ^{inst_addr[31:ADDR_W+2], inst_addr[1:0],
                         data_addr[31:ADDR_W+2], data_addr[1:0]};
`else
  assign wr_be_n = 4'h0;
  assign unused_bits = ^{inst_addr[31:ADDR_W+2], inst_addr[1:0],
                         data_addr[31:ADDR_W+2], data_addr[1:0], data_be};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE)
        inst_rdata_q <= base_ram_data;
      if (state_q == DRD && cnt_q == CNT_W'(RD_WAIT))
        data_rdata_q <= base_ram_data;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (data_req) state_d = data_we ? WSETUP : DRD;
      end
      DRD: begin
        // RD_WAIT settle cycles, then the sampling cycle itself
        if (cnt_q == CNT_W'(RD_WAIT)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WSETUP: begin
        state_d = WPULSE;
        cnt_d   = '0;
      end
      WPULSE: begin
        if (cnt_q == CNT_W'(WR_PULSE - 1)) begin
          state_d = WHOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WHOLD:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pins decode straight from state so an asserted reset parks them on the same edge.
  always_comb begin
    base_ram_ce_n = 1'b1;
    base_ram_oe_n = 1'b1;
    base_ram_we_n = 1'b1;
    base_ram_be_n = 4'hF;
    base_ram_addr = '0;
    bus_drive     = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          base_ram_ce_n = 1'b0;
          base_ram_oe_n = 1'b0;
          base_ram_be_n = 4'h0;
          base_ram_addr = inst_addr[ADDR_W+1:2];
        end
        DRD: begin
          base_ram_ce_n = 1'b0;
          base_ram_oe_n = 1'b0;
          base_ram_be_n = 4'h0;
          base_ram_addr = data_addr[ADDR_W+1:2];
        end
        WSETUP, WHOLD: begin
          base_ram_ce_n = 1'b0;
          base_ram_be_n = wr_be_n;
          base_ram_addr = data_addr[ADDR_W+1:2];
          bus_drive     = 1'b1;
        end
        WPULSE: begin
          base_ram_ce_n = 1'b0;
          base_ram_we_n = 1'b0;
          base_ram_be_n = wr_be_n;
          base_ram_addr = data_addr[ADDR_W+1:2];
          bus_drive     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign base_ram_data = bus_drive ? data_wdata : 32'hz;
  assign inst_rdata    = inst_rdata_q;
  assign data_rdata    = data_rdata_q;
  assign data_ready    = (state_q == DONE);
  assign inst_stop     = (state_q != IDLE) | data_req;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_base_sram_ctrl.sv
// Bench for base_sram_ctrl: SRAM model, directed cases, random ops checked through a scoreboard.
module tb_base_sram_ctrl;
  localparam int RD_WAIT  = 2;
  localparam int WR_PULSE = 1;
  localparam int ADDR_W   = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       inst_addr;
  logic [31:0]       inst_rdata;
  logic              inst_stop;
  logic              data_req;
  logic              data_we;
  logic [3:0]        data_be;
  logic [31:0]       data_addr;
  logic [31:0]       data_wdata;
  logic [31:0]       data_rdata;
  logic              data_ready;
  logic [ADDR_W-1:0] base_ram_addr;
  wire  [31:0]       base_ram_data;
  logic [3:0]        base_ram_be_n;
  logic              base_ram_ce_n;
  logic              base_ram_oe_n;
  logic              base_ram_we_n;
  logic [2:0]        dbg_state;

  int checks = 0;
  int errors = 0;
  int ready_cnt = 0;
  logic prev_ready = 1'b0;

  logic [31:0] exp_q[$];
  logic        kind_q[$];   // 1 = read (compare data), 0 = write

  logic [31:0] sram_mem [0:1023];
  logic [31:0] ref_mem  [0:1023];
  logic [31:0] sram_drv;
  logic        sram_oe;

  base_sram_ctrl #(.RD_WAIT(RD_WAIT), .WR_PULSE(WR_PULSE), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_stop(inst_stop),
    .data_req(data_req), .data_we(data_we), .data_be(data_be),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_ready(data_ready),
    .base_ram_addr(base_ram_addr), .base_ram_data(base_ram_data),
    .base_ram_be_n(base_ram_be_n), .base_ram_ce_n(base_ram_ce_n),
    .base_ram_oe_n(base_ram_oe_n), .base_ram_we_n(base_ram_we_n),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM model: reads combinationally, commits writes while we_n is low.
  always_comb begin
    sram_oe  = !base_ram_ce_n && !base_ram_oe_n && base_ram_we_n;
    sram_drv = sram_mem[base_ram_addr[9:0]];
  end
  assign base_ram_data = sram_oe ? sram_drv : 32'hz;

  always @(negedge clk) begin
    if (!rst && !base_ram_ce_n && !base_ram_we_n)
      for (int b = 0; b < 4; b++)
        if (!base_ram_be_n[b])
          sram_mem[base_ram_addr[9:0]][8*b +: 8] <= base_ram_data[8*b +: 8];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] expected_be_n(input logic [3:0] be);
`ifdef SRAM_BYTE_WRITE_EN
    return {28'h0, ~be};
`else
    return be == be ? 32'h0 : 32'h0;
`endif
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
`ifdef SRAM_BYTE_WRITE_EN
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
`else
    return (be == be) ? nw : old;
`endif
  endfunction

  // Monitor: bus invariants every cycle, scoreboard pop on each completion pulse.
  always @(negedge clk) begin
    if (!rst) begin
      check("oe_we_overlap", {31'h0, !base_ram_oe_n && !base_ram_we_n}, 32'h0);
      check("inst_stop", {31'h0, inst_stop}, {31'h0, data_req});
      if (data_ready) begin
        ready_cnt++;
        check("ready_width", {31'h0, prev_ready}, 32'h0);
        if (kind_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: got pulse expected none");
        end else begin
          logic [31:0] e;
          logic        k;
          e = exp_q.pop_front();
          k = kind_q.pop_front();
          if (k) check("data_rdata", data_rdata, e);
        end
      end
    end
    prev_ready = data_ready;
  end

  // Starts and ends at posedge+#1. keep=1 leaves data_req high for a back-to-back follower.
  task automatic data_op(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit keep);
    int lat;
    int wl;
    int idx;
    idx = int'(addr[11:2]);
    data_req = 1'b1; data_we = we; data_be = be; data_addr = addr; data_wdata = wdata;
    if (we) begin
      ref_mem[idx] = merge(ref_mem[idx], wdata, be);
      exp_q.push_back(32'h0); kind_q.push_back(1'b0);
    end else begin
      exp_q.push_back(ref_mem[idx]); kind_q.push_back(1'b1);
    end
    lat = 0; wl = 0;
    forever begin
      @(negedge clk);
      if (!base_ram_we_n) begin
        wl++;
        check("wr_be_n", {28'h0, base_ram_be_n}, expected_be_n(be));
        check("wr_addr", {12'h0, base_ram_addr}, {12'h0, addr[21:2]});
      end
      if (data_ready) break;
      lat++;
      if (lat > 40) begin
        checks++; errors++;
        $display("FAIL ready_timeout: got no ready after %0d cycles expected ready", lat);
        break;
      end
    end
    check("latency", lat, we ? 3 + WR_PULSE : RD_WAIT + 2);
    check("we_low_cycles", wl, we ? WR_PULSE : 0);
    @(posedge clk); #1;
    if (!keep) data_req = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] addr);
    inst_addr = addr;
    @(negedge clk);
    check("fetch_addr", {12'h0, base_ram_addr}, {12'h0, addr[21:2]});
    check("fetch_ce_oe", {30'h0, base_ram_ce_n, base_ram_oe_n}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("inst_rdata", inst_rdata, ref_mem[int'(addr[11:2])]);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int rc;
    logic [31:0] a, w;
    for (int i = 0; i < 1024; i++) begin
      sram_mem[i] = i * 32'h9E3779B9 + 32'h01234567;
      ref_mem[i]  = sram_mem[i];
    end
    sram_mem[16'h10] = 32'h3C011234; ref_mem[16'h10] = 32'h3C011234;
    sram_mem[16'h40] = 32'hCAFEF00D; ref_mem[16'h40] = 32'hCAFEF00D;

    rst = 1'b1; inst_addr = 32'h0; data_req = 1'b0; data_we = 1'b0;
    data_be = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ce_n", {31'h0, base_ram_ce_n}, 32'h1);
    check("rst_oe_n", {31'h0, base_ram_oe_n}, 32'h1);
    check("rst_we_n", {31'h0, base_ram_we_n}, 32'h1);
    check("rst_be_n", {28'h0, base_ram_be_n}, 32'hF);
    check("rst_addr", {12'h0, base_ram_addr}, 32'h0);
    check("rst_inst_rdata", inst_rdata, 32'h0);
    check("rst_data_rdata", data_rdata, 32'h0);
    check("rst_ready", {31'h0, data_ready}, 32'h0);
    check("rst_inst_stop", {31'h0, inst_stop}, 32'h0);
    check("rst_state", {29'h0, dbg_state}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_fetch(32'h80000040);
    data_op(1'b0, 4'hF, 32'h80000100, 32'h0, 1'b0);
    data_op(1'b1, 4'b0011, 32'h80000200, 32'h11223344, 1'b0);
    data_op(1'b0, 4'hF, 32'h80000200, 32'h0, 1'b0);

    // Fetch in flight, then a data read steals the bus
    inst_addr = 32'h80000040;
    @(posedge clk); #1;
    data_op(1'b0, 4'hF, 32'h80000100, 32'h0, 1'b0);
    check("inst_hold", inst_rdata, ref_mem[16'h10]);
    do_fetch(32'h80000040);

    rc = ready_cnt;
    data_op(1'b1, 4'hF, 32'h80000280, 32'hA5A5_0001, 1'b1);
    data_op(1'b1, 4'hF, 32'h80000284, 32'hA5A5_0002, 1'b0);
    check("b2b_ready_count", ready_cnt - rc, 2);
    data_op(1'b0, 4'hF, 32'h80000280, 32'h0, 1'b1);
    data_op(1'b0, 4'hF, 32'h80000284, 32'h0, 1'b0);

    // Reset asserted while we_n is low
    rc = ready_cnt;
    data_req = 1'b1; data_we = 1'b1; data_be = 4'hF;
    data_addr = 32'h80000010; data_wdata = 32'hDEADBEEF;
    for (int i = 0; i < 20 && base_ram_we_n; i++) @(negedge clk);
    check("abort_reached_pulse", {31'h0, base_ram_we_n}, 32'h0);
    #2 rst = 1'b1;
    #1;
    check("abort_we_n", {31'h0, base_ram_we_n}, 32'h1);
    check("abort_ce_n", {31'h0, base_ram_ce_n}, 32'h1);
    check("abort_oe_n", {31'h0, base_ram_oe_n}, 32'h1);
    data_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_no_ready", ready_cnt - rc, 0);
    @(posedge clk); #1;

    for (int n = 0; n < 40; n++) begin
      a = 32'h80000000 | ({22'h0, 10'($urandom_range(32, 159))} << 2);
      w = $urandom;
      case ($urandom_range(0, 3))
        0: do_fetch(a);
        1: data_op(1'b0, 4'hF, a, 32'h0, 1'b0);
        2: data_op(1'b1, 4'($urandom_range(0, 15)), a, w, 1'b0);
        default: begin
          data_op(1'b1, 4'($urandom_range(1, 15)), a, w, 1'b1);
          data_op(1'b0, 4'hF, a, 32'h0, 1'b0);
        end
      endcase
    end

    repeat (4) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
